// File: rtl/pulse_seq_fsm_if.sv
// Handshake bundle for pulse_seq_fsm.
// Enable, pulse and ack inputs; flag outputs.
interface pulse_seq_fsm_if #(
  parameter int CH = 4
);
  logic          En;
  logic [CH-1:0] A;
  logic [CH-1:0] Ack;
  logic [CH-1:0] F;
  logic [CH-1:0] G;
  logic [CH-1:0] TO;
  logic          Busy;

  modport master (
    output En, A, Ack,
    input  F, G, TO, Busy
  );

  modport slave (
    input  En, A, Ack,
    output F, G, TO, Busy
  );
endinterface

// File: rtl/pulse_seq_fsm.sv
// Per-channel pulse sequence detector.
// Counts pulses, times gaps, flags done/timeout.
module pulse_seq_fsm #(
  parameter int CH      = 4,
  parameter int PULSES  = 2,
  parameter int TIMEOUT = 15,
  parameter int POL     = 1
) (
  input  logic           Clock,
  input  logic           Reset,
  pulse_seq_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    STOP  = 2'b10,
    CLEAR = 2'b11
  } state_t;

  localparam logic [7:0]  PMAX  = 8'(PULSES);
  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t        state [CH];
  logic [7:0]    cnt   [CH];
  logic [15:0]   tmr   [CH];
  logic [CH-1:0] to_q;
  logic [CH-1:0] act;

  always_comb begin
    act = (POL != 0) ? bus.A : ~bus.A;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < CH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
        tmr[i]   <= '0;
      end
      to_q <= '0;
    end else if (!bus.En) begin
      to_q <= '0;
    end else begin
      to_q <= '0;
      for (int i = 0; i < CH; i++) begin
        case (state[i])
          IDLE: begin
            if (act[i]) begin
              state[i] <= START;
              cnt[i]   <= '0;
            end
          end
          START: begin
            if (!act[i]) begin
              cnt[i] <= cnt[i] + 8'd1;
              tmr[i] <= '0;
              state[i] <= (cnt[i] + 8'd1 == PMAX)
                        ? CLEAR : STOP;
            end
          end
          STOP: begin
            // act wins over a timeout due the same cycle
            if (act[i]) begin
              state[i] <= START;
            end else if (tmr[i] == TLAST) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
              tmr[i]   <= '0;
              to_q[i]  <= 1'b1;
            end else begin
              tmr[i] <= tmr[i] + 16'd1;
            end
          end
          CLEAR: begin
            if (bus.Ack[i]) state[i] <= IDLE;
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  logic [CH-1:0] f_d;
  logic [CH-1:0] g_d;
  logic [CH-1:0] b_d;

  always_comb begin
    f_d = '0;
    g_d = '0;
    b_d = '0;
    for (int i = 0; i < CH; i++) begin
      f_d[i] = (state[i] == CLEAR);
      g_d[i] = (state[i] == IDLE);
      b_d[i] = (state[i] == START)
            || (state[i] == STOP);
    end
  end

  assign bus.F    = f_d;
  assign bus.G    = g_d;
  assign bus.TO   = to_q;
  assign bus.Busy = |b_d;

endmodule

// File: tb/tb_pulse_seq_fsm.sv
// Vector-table bench for pulse_seq_fsm.
// Second instance covers PULSES=1, POL=0.
module tb_pulse_seq_fsm;

  logic clk = 1'b0;
  logic rst;
  logic rst1;

  always #5 clk = ~clk;

  pulse_seq_fsm_if #(.CH(4)) bus ();
  pulse_seq_fsm_if #(.CH(1)) bus1 ();

  pulse_seq_fsm #(
    .CH(4), .PULSES(2), .TIMEOUT(4), .POL(1)
  ) dut (
    .Clock(clk), .Reset(rst), .bus(bus)
  );

  pulse_seq_fsm #(
    .CH(1), .PULSES(1), .TIMEOUT(2), .POL(0)
  ) dut1 (
    .Clock(clk), .Reset(rst1), .bus(bus1)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] a;
    logic [3:0] ack;
    logic [3:0] f;
    logic [3:0] g;
    logic [3:0] to;
    logic       b;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic add(
    input logic rs, input logic en,
    input logic [3:0] a, input logic [3:0] ack,
    input logic [3:0] f, input logic [3:0] g,
    input logic [3:0] to, input logic b
  );
    vec_t v;
    v.rst = rs; v.en = en; v.a = a; v.ack = ack;
    v.f = f; v.g = g; v.to = to; v.b = b;
    tbl.push_back(v);
  endtask

  task automatic chk(
    input string nm, input int idx,
    input logic [3:0] got, input logic [3:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s row %0d: got %b want %b",
               nm, idx, got, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rst1     = 1'b1;
    bus.En   = 1'b0;
    bus.A    = '0;
    bus.Ack  = '0;
    bus1.En  = 1'b0;
    bus1.A   = 1'b1;
    bus1.Ack = 1'b0;

    // reset held two cycles
    add(1,1,4'h0,4'h0, 4'h0,4'hF,4'h0,0);
    add(1,1,4'h0,4'h0, 4'h0,4'hF,4'h0,0);
    add(0,1,4'h0,4'h0, 4'h0,4'hF,4'h0,0);
    // ch0: high 2, low 2, high 1, low
    add(0,1,4'h1,4'h0, 4'h0,4'hE,4'h0,1);
    add(0,1,4'h1,4'h0, 4'h0,4'hE,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hE,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hE,4'h0,1);
    add(0,1,4'h1,4'h0, 4'h0,4'hE,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h1,4'hE,4'h0,0);
    // CLEAR ignores A and foreign Ack
    add(0,1,4'h1,4'h0, 4'h1,4'hE,4'h0,0);
    add(0,1,4'h0,4'h0, 4'h1,4'hE,4'h0,0);
    add(0,1,4'h1,4'h2, 4'h1,4'hE,4'h0,0);
    add(0,1,4'h0,4'h1, 4'h0,4'hF,4'h0,0);
    // ch1 timeout
    add(0,1,4'h2,4'h0, 4'h0,4'hD,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hD,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hD,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hD,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hD,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hF,4'h2,0);
    add(0,1,4'h0,4'h0, 4'h0,4'hF,4'h0,0);
    // ch1 rises on the 4th gap cycle
    add(0,1,4'h2,4'h0, 4'h0,4'hD,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hD,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hD,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hD,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hD,4'h0,1);
    add(0,1,4'h2,4'h0, 4'h0,4'hD,4'h0,1);
    add(0,1,4'h2,4'h0, 4'h0,4'hD,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h2,4'hD,4'h0,0);
    add(0,1,4'h0,4'h2, 4'h0,4'hF,4'h0,0);
    // ch2 stalled by En=0 with timer at 2
    add(0,1,4'h4,4'h0, 4'h0,4'hB,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hB,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hB,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hB,4'h0,1);
    for (int k = 0; k < 10; k++) begin
      add(0,0,(k % 2 == 0) ? 4'h4 : 4'h0,4'h4,
          4'h0,4'hB,4'h0,1);
    end
    add(0,1,4'h0,4'h0, 4'h0,4'hB,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'hF,4'h4,0);
    add(0,1,4'h0,4'h0, 4'h0,4'hF,4'h0,0);
    // ch0 to CLEAR, ch3 in STOP, then reset
    add(0,1,4'h9,4'h0, 4'h0,4'h6,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h0,4'h6,4'h0,1);
    add(0,1,4'h1,4'h0, 4'h0,4'h6,4'h0,1);
    add(0,1,4'h0,4'h0, 4'h1,4'h6,4'h0,1);
    add(1,1,4'hF,4'hF, 4'h0,4'hF,4'h0,0);
    add(0,1,4'h0,4'h0, 4'h0,4'hF,4'h0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst     = tbl[i].rst;
      bus.En  = tbl[i].en;
      bus.A   = tbl[i].a;
      bus.Ack = tbl[i].ack;
      @(posedge clk);
      #1;
      chk("F", i, bus.F, tbl[i].f);
      chk("G", i, bus.G, tbl[i].g);
      chk("TO", i, bus.TO, tbl[i].to);
      chk("Busy", i, {3'b0, bus.Busy},
          {3'b0, tbl[i].b});
    end

    // PULSES=1, active-low: one low pulse completes
    @(negedge clk);
    rst1 = 1'b0; bus1.En = 1'b1; bus1.A = 1'b1;
    @(posedge clk); #1;
    chk("p1_idle", 0, {3'b0, bus1.G}, 4'h1);
    @(negedge clk);
    bus1.A = 1'b0; bus1.Ack = 1'b1;
    @(posedge clk); #1;
    chk("p1_busy", 1, {3'b0, bus1.Busy}, 4'h1);
    chk("p1_g", 1, {3'b0, bus1.G}, 4'h0);
    @(negedge clk);
    bus1.A = 1'b1; bus1.Ack = 1'b0;
    @(posedge clk); #1;
    chk("p1_f", 2, {3'b0, bus1.F}, 4'h1);
    chk("p1_to", 2, {3'b0, bus1.TO}, 4'h0);
    @(negedge clk);
    bus1.Ack = 1'b1;
    @(posedge clk); #1;
    chk("p1_ack_f", 3, {3'b0, bus1.F}, 4'h0);
    chk("p1_ack_g", 3, {3'b0, bus1.G}, 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pulse_seq_fsm.md
PULSE_SEQ_FSM -- requirements
Module: pulse_seq_fsm

Interface
REQ-001 Parameter CH, default 4: number of independent channels, 1..16.
REQ-002 Parameter PULSES, default 2: complete pulses required per sequence, 1..255.
REQ-003 Parameter TIMEOUT, default 15: maximum gap between pulses, in enabled cycles, 1..65535.
REQ-004 Parameter POL, default 1: active level of A; 1 means a pulse is high, 0 means a pulse is low.
REQ-005 Clock  input  1  single clock; all state updates on the rising edge.
REQ-006 Reset  input  1  synchronous reset, active-high.
REQ-007 En  input  1  global enable; when 0, all channel state, counters and timers hold.
REQ-008 A  input  CH  per-channel pulse input, synchronous to Clock.
REQ-009 Ack  input  CH  per-channel completion acknowledge.
REQ-010 F  output  CH  per-channel sequence-complete flag; high while the channel is in CLEAR.
REQ-011 G  output  CH  per-channel idle flag; high while the channel is in IDLE.
REQ-012 TO  output  CH  per-channel timeout flag; registered, one-cycle pulse.
REQ-013 Busy  output  1  OR over all channels of (state not IDLE and not CLEAR).

Function
REQ-014 Each channel SHALL implement an independent 4-state FSM with a 2-bit encoding: IDLE=00, START=01, STOP=10, CLEAR=11.
REQ-015 Define act[i] = (A[i] == POL); every transition below SHALL occur only on edges where En=1.
REQ-016 IDLE: if act, go to START and clear pulse_cnt to 0; otherwise remain in IDLE.
REQ-017 START: if not act, increment pulse_cnt; go to CLEAR if the incremented value equals PULSES, otherwise go to STOP; if act, remain in START.
REQ-018 On entry to STOP, the gap timer SHALL be cleared to 0.
REQ-019 STOP: if act, go to START; if not act, increment the gap timer.
REQ-020 STOP timeout: on the TIMEOUT-th consecutive enabled inactive cycle, go to IDLE, clear pulse_cnt, and assert TO for exactly the next cycle.
REQ-021 STOP, act in the same cycle the timeout would fire: go to START; no timeout occurs.
REQ-022 CLEAR: if Ack, go to IDLE; otherwise remain in CLEAR regardless of A.
REQ-023 Ack SHALL be ignored in every state except CLEAR.
REQ-024 With PULSES=1, the first falling edge of act in START SHALL go directly to CLEAR.
REQ-025 F and G SHALL be Moore outputs decoded from the state register only, with no combinational path from A, En or Ack.
REQ-026 pulse_cnt SHALL be 8 bits and the gap timer 16 bits; neither SHALL wrap, since the limits in REQ-002 and REQ-003 bound them.
REQ-027 En=0 SHALL hold all state, pulse_cnt and timers, and force TO to 0; no act edges are recorded while disabled.
REQ-028 Latency: a state change SHALL be visible on F, G and Busy one cycle after the sampling edge.
REQ-029 An illegal state SHALL be impossible by construction; the default decode SHALL go to IDLE.

Reset
REQ-030 Reset=1 at a rising edge SHALL force every channel to IDLE, clear pulse_cnt and timers, and give F=0, G=all ones, TO=0 and Busy=0 on the next cycle.
REQ-031 Reset SHALL take priority over En, A and Ack.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence without asserting F or TO.

Verification
Bench parameters: CH=4, PULSES=2, TIMEOUT=4, POL=1.
REQ-033 Reset held 2 cycles, then released -> F=0000, G=1111, TO=0000, Busy=0.
REQ-034 A[0] pattern high 2 cycles, low 2, high 1, low -> ch0 goes START, STOP, START, CLEAR; F[0]=1 one cycle after the second falling edge; other channels stay G=1.
REQ-035 ch0 in CLEAR, then A[0] toggled -> F[0] stays 1; then Ack[0]=1 for one cycle -> G[0]=1 and F[0]=0 next cycle.
REQ-036 ch1 in STOP with A[1]=0 for 4 cycles -> TO[1]=1 for exactly one cycle and G[1]=1; a second run with A[1] rising on the 4th cycle -> ch1 goes START and TO[1] stays 0.
REQ-037 Mid-sequence En=0 for 10 cycles with A[2] toggling -> ch2 state and timer unchanged; after En=1 the sequence resumes where it stopped, and TO[2]=0 throughout the disabled period.
REQ-038 Reset=1 while ch3 is in STOP and ch0 is in CLEAR -> both channels IDLE next cycle, F=0000, TO=0000.
